// File: rtl/avg_pkg.sv
// Shared helpers for the pipelined averaging tree: width derivation and output clamping.
package avg_pkg;

  // Widest intermediate the clamp helper accepts; ACCW must stay below this.
  localparam int MAXW = 64;

  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int accw(input int w, input int n);
    return w + clog2(n);
  endfunction

  // Clamp a MAXW-bit value (already sign- or zero-extended) into w bits.
  // Returns {flag, value}; only the low w bits of value are meaningful.
  function automatic logic [MAXW:0] sat_to_w(input logic [MAXW-1:0] v,
                                             input logic            sgn,
                                             input int              w);
    logic [MAXW-1:0] one;
    logic [MAXW-1:0] hi;
    logic [MAXW-1:0] lo;
    one = MAXW'(1);
    if (sgn) begin
      hi = (one << (w - 1)) - one;
      lo = ~hi;
      if ($signed(v) > $signed(hi)) return {1'b1, hi};
      if ($signed(v) < $signed(lo)) return {1'b1, lo};
    end else begin
      hi = (one << w) - one;
      if (v > hi) return {1'b1, hi};
    end
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/avg_tree_stage.sv
// One registered adder-tree level: NIN lanes of IW bits reduce pairwise to NIN/2 lanes of
// IW+1 bits, carrying valid, shift amount and mode alongside with local load/advance logic.
module avg_tree_stage #(
  parameter int NIN = 8,
  parameter int IW  = 16,
  parameter int SHW = 8
) (
  input  logic                        Clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIN*IW-1:0]           in_data,
  input  logic [SHW-1:0]              in_sa,
  input  logic                        in_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [(NIN/2)*(IW+1)-1:0]   out_data,
  output logic [SHW-1:0]              out_sa,
  output logic                        out_mode
);

  localparam int NOUT = NIN / 2;

  logic [NOUT*(IW+1)-1:0] sums;

  // Each lane is widened by one bit (sign or zero per the captured mode) before adding,
  // so every level's sum is exact.
  always_comb begin
    sums = '0; // NOTE: default first so no path through always_comb can infer a latch.
    for (int k = 0; k < NOUT; k++) begin
      sums[k*(IW+1) +: (IW+1)] =
          {in_mode & in_data[(2*k+1)*IW-1], in_data[(2*k)*IW +: IW]} +
          {in_mode & in_data[(2*k+2)*IW-1], in_data[(2*k+1)*IW +: IW]};
    end
  end

  // Load when empty or when the held vector leaves this cycle (bubble collapse).
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0; // NOTE: non-blocking for every flop so all stages update from pre-edge values.
    end else if (in_ready) begin
      out_valid <= in_valid;
    end
  end

  // NOTE: payload flops have no reset; the valid bit alone says whether they hold a vector.
  always_ff @(posedge Clk) begin
    if (in_valid && in_ready) begin
      out_data <= sums;
      out_sa   <= in_sa;
      out_mode <= in_mode;
    end
  end

endmodule

// File: rtl/pipelined_avg_tree.sv
// N-input streaming averager: LVL registered adder levels, then a shift/saturate output
// register, all joined by valid/ready with bubble collapsing.
module pipelined_avg_tree
  import avg_pkg::*;
#(
  parameter int N   = 8,
  parameter int W   = 16,
  parameter int SHW = 8
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*W-1:0]   in_data,
  input  logic [SHW-1:0]   sa,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             sat_flag
);

  localparam int LVL  = clog2(N);
  localparam int ACCW = accw(W, N);

  // Index 0 is the input port; index g+1 is the output of tree level g.
  logic [LVL:0]     lvl_valid;
  logic [LVL:0]     lvl_ready;
  logic [N*W-1:0]   lvl_data [LVL+1];
  logic [SHW-1:0]   lvl_sa   [LVL+1];
  logic             lvl_mode [LVL+1];
  logic             run_q;

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) run_q <= 1'b0;
    else      run_q <= 1'b1;
  end

  assign in_ready     = run_q & lvl_ready[0];
  assign lvl_valid[0] = in_valid & run_q;
  assign lvl_data[0]  = in_data;
  assign lvl_sa[0]    = sa;
  assign lvl_mode[0]  = signed_mode;

  for (genvar g = 0; g < LVL; g++) begin : g_lvl
    localparam int NIN = N >> g;
    localparam int IW  = W + g;

    logic [(NIN/2)*(IW+1)-1:0] q;

    avg_tree_stage #(.NIN(NIN), .IW(IW), .SHW(SHW)) u_stage (
      .Clk       (Clk),
      .rst       (rst),
      .in_valid  (lvl_valid[g]),
      .in_ready  (lvl_ready[g]),
      .in_data   (lvl_data[g][NIN*IW-1:0]),
      .in_sa     (lvl_sa[g]),
      .in_mode   (lvl_mode[g]),
      .out_valid (lvl_valid[g+1]),
      .out_ready (lvl_ready[g+1]),
      .out_data  (q),
      .out_sa    (lvl_sa[g+1]),
      .out_mode  (lvl_mode[g+1])
    );

    assign lvl_data[g+1] = (N*W)'(q);
  end

  logic [ACCW-1:0] sum;
  logic [ACCW-1:0] shifted;
  logic [MAXW-1:0] wide;
  logic [MAXW:0]   sat_res;

  assign sum = lvl_data[LVL][ACCW-1:0];

  // Separate statements keep >>> arithmetic: a mixed-sign ternary would make it logical.
  always_comb begin
    if (lvl_mode[LVL]) shifted = $signed(sum) >>> lvl_sa[LVL];
    else               shifted = sum >> lvl_sa[LVL];
    wide    = {{(MAXW-ACCW){lvl_mode[LVL] & shifted[ACCW-1]}}, shifted};
    sat_res = sat_to_w(wide, lvl_mode[LVL], W);
  end

  assign lvl_ready[LVL] = !out_valid || out_ready;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else if (lvl_ready[LVL]) begin
      out_valid <= lvl_valid[LVL];
      if (lvl_valid[LVL]) begin
        out_data <= W'(sat_res);
        sat_flag <= sat_res[MAXW];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_avg_tree.sv
// Scoreboard bench for pipelined_avg_tree (N=8, W=16): directed corner vectors, random
// streams with back-pressure, and an asynchronous reset in the middle of traffic.
module tb_pipelined_avg_tree;

  localparam int N   = 8;
  localparam int W   = 16;
  localparam int SHW = 8;
  localparam int NW  = N * W;

  logic            Clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [NW-1:0]   in_data;
  logic [SHW-1:0]  sa;
  logic            signed_mode;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            sat_flag;

  pipelined_avg_tree #(.N(N), .W(W), .SHW(SHW)) dut (
    .Clk         (Clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .sa          (sa),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .sat_flag    (sat_flag)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         sat;
    int           cyc;
    logic         lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   cyc       = 0;
  int   last_xfer = 0;
  logic rand_rdy  = 1'b0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask

  // Reference: exact 64-bit sum, shift, then clamp.
  function automatic logic [W:0] model(input logic [NW-1:0] d, input logic [SHW-1:0] s,
                                       input logic m);
    longint acc = 0;
    logic [W-1:0] ch;
    for (int k = 0; k < N; k++) begin
      ch = d[k*W +: W];
      if (m) acc += longint'($signed(ch));
      else   acc += longint'(ch);
    end
    if (m) begin
      if (s >= 63) acc = (acc < 0) ? -1 : 0;
      else         acc = acc >>> s;
      if (acc > 32767)  return {1'b1, 16'h7FFF};
      if (acc < -32768) return {1'b1, 16'h8000};
    end else begin
      if (s >= 63) acc = 0;
      else         acc = acc >> s;
      if (acc > 65535) return {1'b1, 16'hFFFF};
    end
    return {1'b0, acc[W-1:0]};
  endfunction

  function automatic logic [NW-1:0] fill(input logic [W-1:0] v);
    logic [NW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = v;
    return r;
  endfunction

  // Called and returns at posedge+1; pushes the expectation at the accepting cycle.
  task automatic send(input logic [NW-1:0] d, input logic [SHW-1:0] s, input logic m,
                      input logic [W:0] want, input logic lat);
    int waited = 0;
    in_data     = d;
    sa          = s;
    signed_mode = m;
    in_valid    = 1'b1;
    @(negedge Clk);
    while (!in_ready && waited < 200) begin
      @(negedge Clk);
      waited++;
    end
    if (waited >= 200) begin
      check("accept_timeout", 0, 1);
    end else begin
      sb.push_back('{data: want[W-1:0], sat: want[W], cyc: cyc, lat: lat});
      last_xfer = cyc;
    end
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [NW-1:0]  d;
    logic [SHW-1:0] s;
    logic           m;
    d = {$urandom, $urandom, $urandom, $urandom};
    s = SHW'($urandom_range(0, 24));
    m = 1'($urandom_range(0, 1));
    send(d, s, m, model(d, s, m), 1'b0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge Clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    #1;
  endtask

  // Output monitor: in-order scoreboard, latency on tagged vectors, stability under stall.
  initial begin : monitor
    exp_t         e;
    logic         hold_v = 1'b0;
    logic [W-1:0] hold_d = '0;
    logic         hold_s = 1'b0;
    forever begin
      @(negedge Clk);
      if (!rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v && out_valid) begin
          check("stall_data", out_data, hold_d);
          check("stall_sat", sat_flag, hold_s);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("sat_flag", sat_flag, e.sat);
            if (e.lat) check("latency", cyc - e.cyc, 4);
          end
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        hold_s = sat_flag;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NW-1:0] d;
    int first;
    int acc_n;
    int n;
    int stale;

    rst         = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    sa          = '0;
    signed_mode = 1'b0;
    out_ready   = 1'b1;

    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_in_ready", in_ready, 0);
    #10;
    rst = 1'b1;
    @(posedge Clk);
    #1;
    check("ready_after_rst", in_ready, 1);

    // Channels 1..8, sa=3 signed: 36>>3 = 4 with latency 4.
    d = '0;
    for (int k = 0; k < N; k++) d[k*W +: W] = W'(k + 1);
    send(d, 3, 1'b1, {1'b0, 16'd4}, 1'b1);
    wait_drain();

    // Signed extremes and floor rounding.
    send(fill(16'h8000), 0, 1'b1, {1'b1, 16'h8000}, 1'b0);
    send(fill(16'h8000), 3, 1'b1, {1'b0, 16'h8000}, 1'b0);
    d = '0;
    d[15:0]  = 16'hFFF7;
    d[31:16] = 16'h0007;
    send(d, 1, 1'b1, {1'b0, 16'hFFFF}, 1'b0);

    // Unsigned extremes, including an oversized shift.
    send(fill(16'hFFFF), 3,   1'b0, {1'b0, 16'hFFFF}, 1'b0);
    send(fill(16'hFFFF), 0,   1'b0, {1'b1, 16'hFFFF}, 1'b0);
    send(fill(16'hFFFF), 200, 1'b0, {1'b0, 16'h0000}, 1'b0);

    // Shift past ACCW in signed mode, then per-vector mode alternation.
    d = '0;
    d[15:0] = 16'hFFFB;
    send(d, 40, 1'b1, {1'b0, 16'hFFFF}, 1'b0);
    d[15:0] = 16'h0005;
    send(d, 40, 1'b1, {1'b0, 16'h0000}, 1'b0);
    d[15:0] = 16'h8000;
    send(d, 1, 1'b0, {1'b0, 16'h4000}, 1'b0);
    send(d, 1, 1'b1, {1'b0, 16'hC000}, 1'b0);
    send(d, 1, 1'b0, {1'b0, 16'h4000}, 1'b0);
    send(d, 1, 1'b1, {1'b0, 16'hC000}, 1'b0);
    wait_drain();

    // 20 back-to-back random vectors at full rate.
    first = 0;
    for (int i = 0; i < 20; i++) begin
      send_rand();
      if (i == 0) first = last_xfer;
    end
    check("full_rate", last_xfer - first, 19);
    wait_drain();

    // Blocked output: the pipeline should absorb exactly 4 vectors.
    out_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) begin
        send_rand();
        acc_n++;
      end else begin
        @(posedge Clk);
        #1;
      end
    end
    check("fill_depth", acc_n, 4);
    check("ready_low_when_full", in_ready, 0);

    // Random back-pressure while streaming more vectors.
    rand_rdy = 1'b1;
    fork
      begin
        while (rand_rdy) begin
          @(posedge Clk);
          #1;
          if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 16; i++) send_rand();
    wait_drain();
    rand_rdy = 1'b0;
    @(posedge Clk);
    #2;
    out_ready = 1'b1;
    @(posedge Clk);
    #1;

    // Asynchronous reset with three vectors in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand();
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("prefill_out_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_sat_flag", sat_flag, 0);
    sb.delete();
    @(posedge Clk);
    #3;
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge Clk);
    #1;
    check("ready_after_async_rst", in_ready, 1);
    stale = 0;
    repeat (6) begin
      @(negedge Clk);
      if (out_valid) stale++;
    end
    check("no_stale_output", stale, 0);
    @(posedge Clk);
    #1;
    send(fill(16'h0010), 3, 1'b1, {1'b0, 16'h0010}, 1'b1);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
